// File: rtl/spram_byte_ctrl.sv
// Byte-wide valid/ready front end for one SB_SPRAM256KA (16K x 16), with
// nibble-masked lane writes and idle-driven STANDBY parking.
module spram_byte_ctrl #(
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [14:0] addr,
    input  logic [7:0]  wdata,
    output logic        ready,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic [13:0] ram_addr,
    output logic [15:0] ram_datain,
    output logic [3:0]  ram_maskwren,
    output logic        ram_wren,
    output logic        ram_cs,
    output logic        ram_standby,
    output logic        ram_sleep,
    output logic        ram_poweroff,
    input  logic [15:0] ram_dataout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACCESS  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_STBY    = 3'd3;
    localparam logic [2:0] S_WAKE    = 3'd4;

    localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int WW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES + 1) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_CYCLES);

    logic [2:0]    state;
    logic [IW-1:0] idle_cnt;
    logic [WW-1:0] wake_cnt;

    logic        cmd_we;
    logic [14:0] cmd_addr;
    logic [7:0]  cmd_wdata;

    logic        accept;
    logic        launch;
    logic        l_we;
    logic [14:0] l_addr;
    logic [7:0]  l_wdata;

    function automatic logic [3:0] lane_mask(input logic wr, input logic lane);
        if (!wr)
            return 4'b0000;
        return lane ? 4'b1100 : 4'b0011;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
        return lane ? word[15:8] : word[7:0];
    endfunction

    assign ram_sleep    = 1'b0;
    assign ram_poweroff = 1'b1;

    // A launch drives the SPRAM either straight from the host (IDLE) or from
    // the command parked while STANDBY was being released (WAKE).
    always_comb begin
        accept  = req & ready;
        launch  = ((state == S_IDLE) & accept) |
                  ((state == S_WAKE) & (wake_cnt == WW'(1)));
        l_we    = (state == S_IDLE) ? we    : cmd_we;
        l_addr  = (state == S_IDLE) ? addr  : cmd_addr;
        l_wdata = (state == S_IDLE) ? wdata : cmd_wdata;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_we    <= we;
            cmd_addr  <= addr;
            cmd_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            idle_cnt     <= '0;
            wake_cnt     <= '0;
            ready        <= 1'b1;
            ack          <= 1'b0;
            rdata        <= '0;
            ram_cs       <= 1'b0;
            ram_wren     <= 1'b0;
            ram_maskwren <= '0;
            ram_addr     <= '0;
            ram_datain   <= '0;
            ram_standby  <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (launch) begin
                ram_cs       <= 1'b1;
                ram_wren     <= l_we;
                ram_addr     <= l_addr[14:1];
                ram_datain   <= {l_wdata, l_wdata};
                ram_maskwren <= lane_mask(l_we, l_addr[0]);
                ready        <= 1'b0;
                idle_cnt     <= '0;
                state        <= S_ACCESS;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (IDLE_CYCLES != 0) begin
                            if (idle_cnt == IDLE_LAST) begin
                                ram_standby <= 1'b1;
                                idle_cnt    <= '0;
                                state       <= S_STBY;
                            end else begin
                                idle_cnt <= idle_cnt + IW'(1);
                            end
                        end
                    end
                    // SPRAM samples the command on this edge; release the bus.
                    S_ACCESS: begin
                        ram_cs       <= 1'b0;
                        ram_wren     <= 1'b0;
                        ram_maskwren <= '0;
                        if (cmd_we) begin
                            ack   <= 1'b1;
                            ready <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        rdata <= lane_byte(ram_dataout, cmd_addr[0]);
                        ack   <= 1'b1;
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end
                    S_STBY: begin
                        if (accept) begin
                            ram_standby <= 1'b0;
                            wake_cnt    <= WAKE_LOAD;
                            ready       <= 1'b0;
                            state       <= S_WAKE;
                        end
                    end
                    S_WAKE: begin
                        wake_cnt <= wake_cnt - WW'(1);
                    end
                    default: begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/spram_byte_ctrl.md
Name: spram_byte_ctrl

Overview:
- Host-side controller that drives one iCE40 SPRAM (SB_SPRAM256KA primitive, 16K x 16).
- Presents a 32 KB byte-addressed valid/ready port to the CPU/video side of the Spectrum core.
- Maps byte accesses onto 16-bit words using nibble write masks.
- Manages the SPRAM STANDBY pin: parks the RAM after a programmable idle period and wakes it on demand.

Parameters:
- IDLE_CYCLES, 64, consecutive idle cycles in IDLE before entering standby; 0 = standby never used.
- WAKE_CYCLES, 2, cycles STANDBY must be low before the first access after wake; minimum 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  host command valid; accepted on an edge where req & ready.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  15  byte address; addr[14:1] = word, addr[0] = byte lane.
- wdata  in  8  write byte; sampled with req.
- ready  out  1  controller can accept a command this cycle.
- ack  out  1  one-cycle pulse: write done, or read data valid on rdata.
- rdata  out  8  read byte; holds its value until the next read ack.
- ram_addr  out  14  to SPRAM ADDRESS.
- ram_datain  out  16  to SPRAM DATAIN.
- ram_maskwren  out  4  to SPRAM MASKWREN.
- ram_wren  out  1  to SPRAM WREN.
- ram_cs  out  1  to SPRAM CHIPSELECT.
- ram_standby  out  1  to SPRAM STANDBY.
- ram_sleep  out  1  to SPRAM SLEEP; constant 0.
- ram_poweroff  out  1  to SPRAM POWEROFF (active-low off); constant 1.
- ram_dataout  in  16  from SPRAM DATAOUT.

Behaviour:
- All outputs are registered except the two constants.
- Reset values:
  - ready=1, ack=0, rdata=0.
  - ram_cs=0, ram_wren=0, ram_maskwren=0, ram_addr=0, ram_datain=0, ram_standby=0.
  - State IDLE, idle counter 0.
- Reset asserted mid-access aborts the access with no ack. A write whose ram_cs/ram_wren are already high at reset assertion may or may not land.
- States:
  - IDLE, ACCESS, CAPTURE, STBY, WAKE.
- IDLE:
  - On accept at edge E0:
    - Latch we, addr, wdata.
    - Drive ram_cs=1, ram_wren=we, ram_addr=addr[14:1], ram_datain={wdata,wdata}.
    - ram_maskwren = addr[0] ? 4'b1100 : 4'b0011 for writes, 4'b0000 for reads.
    - ready=0; go to ACCESS.
  - Otherwise the idle counter increments.
  - When the counter reaches IDLE_CYCLES (nonzero): ram_standby<=1, go to STBY, counter cleared.
  - Any accept clears the counter.
- ACCESS, edge E1 (SPRAM samples here):
  - Drive ram_cs=0, ram_wren=0, ram_maskwren=0.
  - Write: ack<=1, ready<=1, go to IDLE. Ack is high in the 2nd cycle after accept.
  - Read: go to CAPTURE.
- CAPTURE, edge E2:
  - rdata <= latched addr[0] ? ram_dataout[15:8] : ram_dataout[7:0].
  - ack<=1, ready<=1, go to IDLE. Read ack is high in the 3rd cycle after accept.
- ack is deasserted on the edge after it rises.
- ready and ack rise together, so a new command may be accepted on the edge where ack is high.
- Throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- STBY:
  - ready=1, ram_standby=1.
  - On accept: latch the command, ram_standby<=0, load the wake counter with WAKE_CYCLES, ready<=0, go to WAKE.
- WAKE:
  - Count down.
  - When the counter reaches 1, perform the E0 drive actions (ram_cs etc.) and go to ACCESS.
  - Accept-to-ack latency increases by WAKE_CYCLES.
- ram_cs and ram_standby are never both 1.
- req while ready=0 is ignored; the host must hold or re-present it.
- addr[0] only selects the lane. A write never alters the other byte of the word.

Test Plan:
- Reset then write 0xA5 to addr 0x0001 -> ram_cs=1, ram_wren=1, ram_addr=0x0000, ram_maskwren=1100, ram_datain=0xA5A5 for exactly one cycle; ack 2 cycles after accept.
- Write 0x3C to 0x0000 and 0xC3 to 0x0001, then read both -> rdata 0x3C and 0xC3; acks 3 cycles after each read accept; SPRAM model word = 0xC33C.
- Back-to-back: req held high for 4 writes -> accepts every 2 cycles, 4 ack pulses, no lost commands; req during ready=0 is not accepted.
- Idle for 64 cycles (default parameters) -> ram_standby rises on the 64th edge; read of 0x7FFF from standby -> ram_standby falls, ram_cs rises after 2 cycles, ack 5 cycles after accept, rdata = high byte of word 0x3FFF.
- IDLE_CYCLES=0 -> ram_standby stays 0 over 1000 idle cycles.
- Assert reset during CAPTURE -> no ack, ready=1, all RAM outputs at reset values; next read completes normally.
